vip_sobel_edge_detector_param: RTL and testbench



---
 rtl/vip_sobel_edge_detector_param.sv | 240 ++++++++++++++++++++++++
 tb/tb_vip_sobel_edge_detector_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vip_sobel_edge_detector_param.sv
// -----------------------------------------------------------------------------
// vip_sobel_edge_detector_param
//
// Sobel edge detector for a streaming luma path. Two line buffers supply the
// two previous rows at the current column. A 3x3 window then feeds a
// four-register pipeline that computes |gx|+|gy|. The block produces a binary
// edge flag and a mode-dependent magnitude pixel. Threshold and mode are
// shadowed on the vsync rising edge, so a frame is always processed with one
// consistent configuration.
//
// Ports
//   clk, rst_n                   pixel clock, asynchronous active-low reset
//   per_frame_vsync/href/clken   input sidebands (frame sync, line valid, strobe)
//   per_img_y      [DATA_W]      input luma
//   cfg_threshold  [DATA_W+3]    edge threshold (taken at next vsync rise)
//   cfg_mode       [2]           output mode (taken at next vsync rise)
//   post_frame_vsync/href/clken  sidebands delayed by 4 clk
//   post_img_bit                 edge flag
//   post_img_mag   [DATA_W]      magnitude / mode-dependent pixel
// -----------------------------------------------------------------------------
module vip_sobel_edge_detector_param #(
    parameter int DATA_W    = 8,
    parameter int IMG_W_MAX = 1024,
    parameter int ADDR_W    = 10,
    parameter int THR_RST   = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_y,
    input  logic [DATA_W+2:0] cfg_threshold,
    input  logic [1:0]        cfg_mode,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic              post_img_bit,
    output logic [DATA_W-1:0] post_img_mag
);
    localparam int SUM_W = DATA_W + 2;
    localparam int MAG_W = DATA_W + 3;
    // One extra bit lets the column counter represent "past the line buffer".
    localparam int COL_W = ADDR_W + 1;
    localparam logic [COL_W-1:0] COL_LIM = COL_W'(IMG_W_MAX);

    // ---------------- sideband edges, counters, config shadow ----------------
    logic              vsync_prev_q, href_prev_q;
    logic              vsync_rise, href_fall, pix_valid, in_range, border_in;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              row_valid_q, row_valid_d;
    logic [MAG_W-1:0]  thr_q;
    logic [1:0]        mode_q;

    assign vsync_rise = per_frame_vsync & ~vsync_prev_q;
    assign href_fall  = href_prev_q & ~per_frame_href;
    assign pix_valid  = per_frame_clken & per_frame_href;
    assign in_range   = (col_q < COL_LIM);

    // A pixel that coincides with the vsync rise belongs to row 0. Until the
    // first vsync after reset, the row count is meaningless.
    assign border_in = vsync_rise | ~row_valid_q | (row_q < ADDR_W'(2)) |
                       (col_q < COL_W'(2)) | ~in_range;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        row_valid_d = row_valid_q | vsync_rise;
        if (href_fall)
            col_d = '0;
        else if (pix_valid && in_range)
            col_d = col_q + COL_W'(1);
        if (vsync_rise)
            row_d = '0;
        else if (href_fall && (row_q != '1))
            row_d = row_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            row_valid_q  <= 1'b0;
            thr_q        <= MAG_W'(THR_RST);
            mode_q       <= 2'b00;
        end else begin
            vsync_prev_q <= per_frame_vsync;
            href_prev_q  <= per_frame_href;
            col_q        <= col_d;
            row_q        <= row_d;
            row_valid_q  <= row_valid_d;
            if (vsync_rise) begin
                thr_q  <= cfg_threshold;
                mode_q <= cfg_mode;
            end
        end
    end

    // ---------------- line buffers ----------------
    logic [DATA_W-1:0] ram1_mem [IMG_W_MAX];
    logic [DATA_W-1:0] ram2_mem [IMG_W_MAX];
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] col_new [3];
    logic              wr2_en_q;
    logic [ADDR_W-1:0] wr2_addr_q;

    assign rd_addr = col_q[ADDR_W-1:0];

    // Column entering the window: row r-2, row r-1, current pixel.
    always_comb begin
        col_new[0] = '0;
        col_new[1] = '0;
        col_new[2] = per_img_y;
        if (in_range) begin
            col_new[0] = ram2_mem[rd_addr];
            col_new[1] = ram1_mem[rd_addr];
        end
    end

    // ---------------- stage 1: 3x3 window ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [DATA_W-1:0] tap_q [3];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tap_q[0] <= '0;
                tap_q[1] <= '0;
                tap_q[2] <= '0;
            end else if (pix_valid) begin
                tap_q[0] <= tap_q[1];
                tap_q[1] <= tap_q[2];
                tap_q[2] <= col_new[gi];
            end
        end
    end

    // RAM1 is read-before-write at the current column. RAM2 takes the RAM1
    // read data one clock later from the registered window tap, so both
    // memories only ever see registered write data.
    always_ff @(posedge clk) begin
        if (pix_valid && in_range)
            ram1_mem[rd_addr] <= per_img_y;
        if (wr2_en_q)
            ram2_mem[wr2_addr_q] <= g_row[1].tap_q[2];
    end

    logic [DATA_W-1:0] p11, p12, p13, p21, p23, p31, p32, p33;
    assign p11 = g_row[0].tap_q[0];
    assign p12 = g_row[0].tap_q[1];
    assign p13 = g_row[0].tap_q[2];
    assign p21 = g_row[1].tap_q[0];
    assign p23 = g_row[1].tap_q[2];
    assign p31 = g_row[2].tap_q[0];
    assign p32 = g_row[2].tap_q[1];
    assign p33 = g_row[2].tap_q[2];

    function automatic logic [SUM_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    // ---------------- stages 2..4 and sidebands ----------------
    logic             border_s1_q, border_s2_q, border_s3_q;
    logic [SUM_W-1:0] gx_r_q, gx_l_q, gy_t_q, gy_b_q;
    logic [SUM_W-1:0] gx_q, gy_q;
    logic [3:0]       vs_q, hr_q, ce_q;
    logic             bit_q, bit_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [MAG_W-1:0] mag_sum;
    logic             edge_hit;
    logic [DATA_W-1:0] mag_sat;

    always_comb begin
        mag_sum  = MAG_W'(gx_q) + MAG_W'(gy_q);
        edge_hit = (mag_sum >= thr_q);
        mag_sat  = (|mag_sum[MAG_W-1:DATA_W]) ? '1 : mag_sum[DATA_W-1:0];
        bit_d    = 1'b0;
        mag_d    = '0;
        case (mode_q)
            2'b00: begin bit_d = edge_hit;  mag_d = edge_hit  ? '1 : '0;      end
            2'b01: begin bit_d = edge_hit;  mag_d = mag_sat;                  end
            2'b10: begin bit_d = ~edge_hit; mag_d = ~edge_hit ? '1 : '0;      end
            default: begin bit_d = edge_hit; mag_d = edge_hit ? mag_sat : '0; end
        endcase
        // Border and blanking win over every mode, including the inverted one.
        if (border_s3_q || !hr_q[2]) begin
            bit_d = 1'b0;
            mag_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr2_en_q    <= 1'b0;
            wr2_addr_q  <= '0;
            border_s1_q <= 1'b0;
            border_s2_q <= 1'b0;
            border_s3_q <= 1'b0;
            gx_r_q      <= '0;
            gx_l_q      <= '0;
            gy_t_q      <= '0;
            gy_b_q      <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            vs_q        <= '0;
            hr_q        <= '0;
            ce_q        <= '0;
            bit_q       <= 1'b0;
            mag_q       <= '0;
        end else begin
            wr2_en_q   <= pix_valid & in_range;
            wr2_addr_q <= rd_addr;
            if (pix_valid)
                border_s1_q <= border_in;
            gx_r_q      <= wsum(p13, p23, p33);
            gx_l_q      <= wsum(p11, p21, p31);
            gy_t_q      <= wsum(p11, p12, p13);
            gy_b_q      <= wsum(p31, p32, p33);
            border_s2_q <= border_s1_q;
            gx_q        <= (gx_r_q >= gx_l_q) ? gx_r_q - gx_l_q : gx_l_q - gx_r_q;
            gy_q        <= (gy_t_q >= gy_b_q) ? gy_t_q - gy_b_q : gy_b_q - gy_t_q;
            border_s3_q <= border_s2_q;
            vs_q        <= {vs_q[2:0], per_frame_vsync};
            hr_q        <= {hr_q[2:0], per_frame_href};
            ce_q        <= {ce_q[2:0], per_frame_clken};
            bit_q       <= bit_d;
            mag_q       <= mag_d;
        end
    end

    assign post_frame_vsync = vs_q[3];
    assign post_frame_href  = hr_q[3];
    assign post_frame_clken = ce_q[3];
    assign post_img_bit     = bit_q;
    assign post_img_mag     = mag_q;

endmodule

// File: tb/tb_vip_sobel_edge_detector_param.sv
// -----------------------------------------------------------------------------
// tb_vip_sobel_edge_detector_param
//
// The stimulus drives whole frames from an image array. For every strobed
// pixel it pushes the expected {bit, mag}, computed directly from the image
// with Sobel arithmetic, into a queue. A monitor on the falling edge pops and
// compares that queue whenever the DUT presents a valid output pixel. The
// monitor also checks the delayed sidebands, blanking, and the reset outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vip_sobel_edge_detector_param;
    localparam int DATA_W    = 8;
    localparam int IMG_W_MAX = 20;
    localparam int ADDR_W    = 5;
    localparam int THR_RST   = 128;
    localparam int THR_W     = DATA_W + 3;
    localparam int MAXV      = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              per_frame_vsync = 1'b0;
    logic              per_frame_href = 1'b0;
    logic              per_frame_clken = 1'b0;
    logic [DATA_W-1:0] per_img_y = '0;
    logic [THR_W-1:0]  cfg_threshold = '0;
    logic [1:0]        cfg_mode = '0;
    logic              post_frame_vsync, post_frame_href, post_frame_clken;
    logic              post_img_bit;
    logic [DATA_W-1:0] post_img_mag;

    always #5 clk = ~clk;

    vip_sobel_edge_detector_param #(
        .DATA_W(DATA_W), .IMG_W_MAX(IMG_W_MAX), .ADDR_W(ADDR_W), .THR_RST(THR_RST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
        .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_img_bit(post_img_bit),
        .post_img_mag(post_img_mag)
    );

    typedef struct {
        int              r;
        int              c;
        logic [DATA_W:0] v;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q [$];
    logic [2:0] hist [4];
    int   img [32][32];
    int   act_thr = THR_RST;
    int   act_mode = 0;
    bit   model_valid = 1'b0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_cmp++;
            if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit, post_img_mag} != '0) begin
                n_err++;
                $display("FAIL reset_outputs got vs=%0b hr=%0b ce=%0b bit=%0b mag=%0d required all 0",
                         post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit, post_img_mag);
            end
            for (int i = 0; i < 4; i++) hist[i] = 3'b000;
        end else begin
            n_cmp++;
            if ({post_frame_vsync, post_frame_href, post_frame_clken} !== hist[3]) begin
                n_err++;
                $display("FAIL sideband_delay got %03b required %03b",
                         {post_frame_vsync, post_frame_href, post_frame_clken}, hist[3]);
            end
            if (post_frame_href && post_frame_clken) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pixel_underflow got bit=%0b mag=%0d required no pixel",
                             post_img_bit, post_img_mag);
                end else begin
                    e = exp_q.pop_front();
                    if ({post_img_bit, post_img_mag} !== e.v) begin
                        n_err++;
                        $display("FAIL pixel r=%0d c=%0d got bit=%0b mag=%0d required bit=%0b mag=%0d",
                                 e.r, e.c, post_img_bit, post_img_mag, e.v[DATA_W], e.v[DATA_W-1:0]);
                    end
                end
            end else if (!post_frame_href) begin
                n_cmp++;
                if (post_img_bit || (post_img_mag != '0)) begin
                    n_err++;
                    $display("FAIL blank_mask got bit=%0b mag=%0d required 0", post_img_bit, post_img_mag);
                end
            end
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {per_frame_vsync, per_frame_href, per_frame_clken};
        end
    end

    // ---------------- reference model and stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int r, input int c);
        exp_t e;
        int   gx, gy, mag, sat, m;
        bit   hit, b;
        b = 1'b0;
        m = 0;
        if (model_valid && r >= 2 && c >= 2 && c < IMG_W_MAX) begin
            gx  = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) -
                  (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy  = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]) -
                  (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            sat = (mag > MAXV) ? MAXV : mag;
            hit = (mag >= act_thr);
            case (act_mode)
                0: begin b = hit;  m = hit ? MAXV : 0; end
                1: begin b = hit;  m = sat;            end
                2: begin b = !hit; m = !hit ? MAXV : 0; end
                default: begin b = hit; m = hit ? sat : 0; end
            endcase
        end
        e.r = r;
        e.c = c;
        e.v = {b, DATA_W'(m)};
        exp_q.push_back(e);
    endtask

    task automatic fill_image(input int pat, input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                case (pat)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c >= 10) ? 200 : 0;
                    2: img[r][c] = (r >= 4) ? 50 : 0;
                    default: img[r][c] = int'($urandom_range(0, MAXV));
                endcase
    endtask

    task automatic pulse_reset();
        per_frame_clken = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_valid = 1'b0;
        tick();
        tick();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input int w, input int h, input int pat, input int thr,
                             input int mode, input bit gate, input int chg_row,
                             input int chg_thr, input int rst_row, input int rst_col);
        fill_image(pat, w, h);
        cfg_threshold = THR_W'(thr);
        cfg_mode      = 2'(mode);
        tick();
        per_frame_vsync = 1'b1;
        act_thr     = thr;
        act_mode    = mode;
        model_valid = 1'b1;
        tick();
        tick();
        per_frame_vsync = 1'b0;
        tick();
        tick();
        for (int r = 0; r < h; r++) begin
            if (r == chg_row) cfg_threshold = THR_W'(chg_thr);
            per_frame_href = 1'b1;
            for (int c = 0; c < w; c++) begin
                if (r == rst_row && c == rst_col) pulse_reset();
                if (gate) begin
                    for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
                        per_frame_clken = 1'b0;
                        tick();
                    end
                end
                per_frame_clken = 1'b1;
                per_img_y = DATA_W'(img[r][c]);
                push_expect(r, c);
                tick();
            end
            per_frame_clken = 1'b0;
            per_frame_href  = 1'b0;
            per_img_y       = '0;
            repeat (3) tick();
        end
        repeat (4) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        run_frame(16, 8, 0, 128, 1, 1'b0, -1, 0, -1, -1);   // flat image
        run_frame(16, 8, 1, 128, 1, 1'b0, -1, 0, -1, -1);   // vertical step
        run_frame(16, 8, 2, 300, 3, 1'b0, -1, 0, -1, -1);   // horizontal step, below thr
        run_frame(16, 8, 2, 200, 3, 1'b0, -1, 0, -1, -1);   // horizontal step, at thr
        run_frame(16, 8, 1, 128, 2, 1'b0, -1, 0, -1, -1);   // inverted mode
        run_frame(16, 8, 1, 128, 1, 1'b0, 3, 1000, -1, -1); // mid-frame cfg change
        run_frame(16, 8, 1, 1000, 1, 1'b0, -1, 0, -1, -1);  // new threshold takes effect
        run_frame(24, 6, 3, int'($urandom_range(0, 1200)), int'($urandom_range(0, 3)),
                  1'b1, -1, 0, -1, -1);                      // line longer than buffer
        run_frame(16, 8, 3, int'($urandom_range(0, 1200)), 1, 1'b1, -1, 0, 3, 5); // reset mid-line
        run_frame(16, 8, 3, int'($urandom_range(0, 1200)), int'($urandom_range(0, 3)),
                  1'b1, -1, 0, -1, -1);
        run_frame(16, 8, 3, int'($urandom_range(0, 1200)), int'($urandom_range(0, 3)),
                  1'b1, -1, 0, -1, -1);
        repeat (8) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
